fetch_stage: RTL

//   IF stage of the 5-stage RV32I pipeline. Owns the PC and issues in-order requests to instruction memory.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the RV32I core: datapath width, reset vector,
// base opcodes and the canonical NOP encoding.
package cpu_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {inst, pc} pairs between the
// instruction memory and the IF/ID register. Head reads as zero when empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage; flush empties the buffer outright.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order imem requests limited by buffer
// credits, buffers responses and hands {inst, pc} to IF/ID. A redirect
// flushes the buffer and marks every in-flight response to be discarded.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(cpu_pkg::RESET_PC),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_inst,
    output logic [XLEN-1:0]  id_pc
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW:0]     DEPTH_SUM  = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;
    logic               req_fire, rsp_keep;
    logic [CW:0]        credit_used;
    logic [XLEN-1:0]    target_pc;
    logic [32+XLEN-1:0] head_data;

    // Handshakes: buffered plus outstanding words may never exceed the buffer size.
    always_comb begin
        target_pc      = redirect_pc & ALIGN_MASK;
        credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_SUM);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        id_valid       = rst_n && !fifo_empty && !redirect_valid;
        fifo_pop       = id_valid && id_ready;
        rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        fifo_push      = rsp_keep;
        id_inst        = head_data[32+XLEN-1:XLEN];
        id_pc          = head_data[XLEN-1:0];
    end

    // Next PC, response PC and counters; a redirect overrides everything else.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d      = target_pc;
            resp_pc_d = target_pc;
            drop_d    = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end else if (imem_rsp_valid) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Fetch state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, resp_pc_q}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= DEPTH_CNT);

endmodule
